// File: rtl/pulse_receiver_pkg.sv
// pulse_receiver_pkg
// Shared definitions for the pulse receiver capture peripheral: register offsets,
// CTRL/STATUS bit positions, FIFO entry field positions and capture FSM encoding.
package pulse_receiver_pkg;

  // Register offsets
  localparam logic [5:0] AddrCtrl   = 6'h00;
  localparam logic [5:0] AddrStatus = 6'h04;
  localparam logic [5:0] AddrFifo   = 6'h08;

  // CTRL bit positions
  localparam int unsigned CtrlEn         = 0;
  localparam int unsigned CtrlInvert     = 1;
  localparam int unsigned CtrlPinLsb     = 2;
  localparam int unsigned CtrlPrescLsb   = 8;
  localparam int unsigned CtrlFiltLsb    = 12;
  localparam int unsigned CtrlTimeoutLsb = 16;

  // Only defined CTRL fields are stored; reserved bits read back as 0.
  localparam logic [31:0] CtrlWrMask = 32'hFFFF_FF1F;

  // STATUS bit positions
  localparam int unsigned StsEmpty      = 0;
  localparam int unsigned StsFull       = 1;
  localparam int unsigned StsOverflow   = 2;
  localparam int unsigned StsFrameDone  = 3;
  localparam int unsigned StsOccLsb     = 4;
  localparam int unsigned StsIeOverflow = 8;
  localparam int unsigned StsIeFrame    = 9;

  // FIFO read-data field positions
  localparam int unsigned EntValid  = 31;
  localparam int unsigned EntEof    = 17;
  localparam int unsigned EntLevel  = 16;
  localparam int unsigned EntDurLsb = 0;

  typedef enum logic {
    StIdle    = 1'b0,
    StMeasure = 1'b1
  } state_t;

  // Occupancy field is 4 bits wide and saturates rather than wrapping.
  function automatic logic [3:0] sat_occ(input int unsigned count);
    return (count > 32'd15) ? 4'hF : 4'(count);
  endfunction

endpackage

// File: rtl/pulse_receiver_fifo.sv
// pulse_receiver_fifo
// Synchronous single-clock FIFO for capture entries.
// A push while full is accepted only when a pop happens in the same cycle.
// A pop while empty is ignored. o_data always shows the head entry.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_push, i_data    push request and entry
//   i_pop             pop request
//   o_data            head entry (undefined when empty)
//   o_full, o_empty   status
//   o_count           number of stored entries (0..DEPTH)
module pulse_receiver_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0] CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == CntFull);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // When full, the pop frees the slot the push is about to fill.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pulse_receiver_capture.sv
// pulse_receiver_capture
// TinyQV user peripheral measuring level durations on one ui_in pin and queueing
// (eof, level, duration) entries for software.
// Ports:
//   clk, rst         peripheral clock, asynchronous active-high reset
//   ui_in            input PMOD, pin selected by CTRL.pin
//   address          register offset (CTRL 0x00, STATUS 0x04, FIFO 0x08)
//   data_in          write data (32-bit writes only)
//   data_write_n     write size, 2'b11 = none, 2'b10 = 32-bit
//   data_read_n      read size, 2'b11 = none
//   data_out         combinational read data
//   data_ready       always 1
//   user_interrupt   overflow / frame_done gated by their enables
module pulse_receiver_capture
  import pulse_receiver_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DUR_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int unsigned EntryW = DUR_W + 2;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DUR_W-1:0] DurMax = '1;

  // Registers
  logic [31:0]      r_ctrl;
  logic [1:0]       r_sync;
  logic             r_lvl;
  logic             r_lvl_prev;
  logic [3:0]       r_filt_cnt;
  logic [15:0]      r_presc_cnt;
  logic [DUR_W-1:0] r_dur;
  state_t           r_state;
  logic             r_overflow;
  logic             r_frame_done;
  logic [1:0]       r_irq_en;
  logic             r_fifo_rd_q;

  // CTRL fields
  logic        w_en;
  logic        w_invert;
  logic [2:0]  w_pin;
  logic [3:0]  w_presc;
  logic [3:0]  w_filt;
  logic [15:0] w_timeout;

  assign w_en      = r_ctrl[CtrlEn];
  assign w_invert  = r_ctrl[CtrlInvert];
  assign w_pin     = r_ctrl[CtrlPinLsb +: 3];
  assign w_presc   = r_ctrl[CtrlPrescLsb +: 4];
  assign w_filt    = r_ctrl[CtrlFiltLsb +: 4];
  assign w_timeout = r_ctrl[CtrlTimeoutLsb +: 16];

  // Register port decode
  logic w_wr32;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_fifo_rd;
  logic w_pop;

  assign w_wr32      = (data_write_n == 2'b10);
  assign w_wr_ctrl   = w_wr32 && (address == AddrCtrl);
  assign w_wr_status = w_wr32 && (address == AddrStatus);
  assign w_fifo_rd   = (data_read_n != 2'b11) && (address == AddrFifo);
  // Pop only on the first cycle of a read access so a held strobe pops once.
  assign w_pop       = w_fifo_rd && !r_fifo_rd_q;

  // ---------------------------------------------------------------------------
  // Input conditioning: synchroniser, invert, glitch filter
  // ---------------------------------------------------------------------------
  logic w_sync_lvl;
  logic w_lvl_edge;

  assign w_sync_lvl = r_sync[1] ^ w_invert;
  assign w_lvl_edge = r_lvl ^ r_lvl_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= 2'b00;
      r_lvl      <= 1'b0;
      r_lvl_prev <= 1'b0;
      r_filt_cnt <= 4'd0;
    end else begin
      r_sync     <= {r_sync[0], ui_in[w_pin]};
      r_lvl_prev <= r_lvl;
      if (w_sync_lvl != r_lvl) begin
        // Flip after filt+1 consecutive disagreeing cycles.
        if (r_filt_cnt == w_filt) begin
          r_lvl      <= w_sync_lvl;
          r_filt_cnt <= 4'd0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 4'd1;
        end
      end else begin
        r_filt_cnt <= 4'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tick generation and duration counter
  // ---------------------------------------------------------------------------
  logic [15:0] w_presc_max;
  logic        w_tick;
  logic        w_clr_cnt;
  logic        w_run_cnt;

  assign w_presc_max = (16'd1 << w_presc) - 16'd1;
  assign w_tick      = (r_presc_cnt == w_presc_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cnt <= 16'd0;
      r_dur       <= '0;
    end else if (w_clr_cnt) begin
      r_presc_cnt <= 16'd0;
      r_dur       <= '0;
    end else if (w_run_cnt) begin
      r_presc_cnt <= w_tick ? 16'd0 : r_presc_cnt + 16'd1;
      if (w_tick && (r_dur != DurMax)) r_dur <= r_dur + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_t w_state_d;
  logic   w_push;
  logic   w_push_eof;
  logic   w_push_level;
  logic   w_frame_evt;
  logic   w_timeout_hit;

  // A saturated counter below a larger timeout never matches, so no eof.
  assign w_timeout_hit = (w_timeout != 16'd0) && (16'(r_dur) == w_timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d    = r_state;
    w_push       = 1'b0;
    w_push_eof   = 1'b0;
    w_push_level = r_lvl;
    w_frame_evt  = 1'b0;
    w_clr_cnt    = 1'b0;
    w_run_cnt    = 1'b0;
    if (!w_en) begin
      w_state_d = StIdle;
      w_clr_cnt = 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_clr_cnt = 1'b1;
          if (w_lvl_edge) w_state_d = StMeasure;
        end
        StMeasure: begin
          w_run_cnt = 1'b1;
          if (w_lvl_edge) begin
            // r_lvl has already flipped; the finished level is the previous one.
            w_push       = 1'b1;
            w_push_level = r_lvl_prev;
            w_clr_cnt    = 1'b1;
          end else if (w_timeout_hit) begin
            w_push      = 1'b1;
            w_push_eof  = 1'b1;
            w_frame_evt = 1'b1;
            w_clr_cnt   = 1'b1;
            w_state_d   = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry FIFO
  // ---------------------------------------------------------------------------
  logic [EntryW-1:0] w_push_data;
  logic [EntryW-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CntW-1:0]   w_count;
  logic              w_ovf_evt;

  assign w_push_data = {w_push_eof, w_push_level, r_dur};
  // A full FIFO still takes the push when a pop frees a slot this cycle.
  assign w_ovf_evt   = w_push && w_full && !w_pop;

  pulse_receiver_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // ---------------------------------------------------------------------------
  // Registers: CTRL, STATUS sticky bits and enables, read-access tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl       <= 32'd0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_irq_en     <= 2'b00;
      r_fifo_rd_q  <= 1'b0;
    end else begin
      r_fifo_rd_q <= w_fifo_rd;
      if (w_wr_ctrl) r_ctrl <= data_in & CtrlWrMask;
      if (w_wr_status) r_irq_en <= {data_in[StsIeFrame], data_in[StsIeOverflow]};
      // Hardware set wins over a same-cycle software clear.
      if (w_ovf_evt)                                 r_overflow <= 1'b1;
      else if (w_wr_status && data_in[StsOverflow])  r_overflow <= 1'b0;
      if (w_frame_evt)                               r_frame_done <= 1'b1;
      else if (w_wr_status && data_in[StsFrameDone]) r_frame_done <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  logic [31:0] w_status;
  logic [31:0] w_fifo_word;

  always_comb begin
    w_status                    = 32'd0;
    w_status[StsEmpty]          = w_empty;
    w_status[StsFull]           = w_full;
    w_status[StsOverflow]       = r_overflow;
    w_status[StsFrameDone]      = r_frame_done;
    w_status[StsOccLsb +: 4]    = sat_occ(32'(w_count));
    w_status[StsIeOverflow]     = r_irq_en[0];
    w_status[StsIeFrame]        = r_irq_en[1];
  end

  always_comb begin
    w_fifo_word = 32'd0;
    if (!w_empty) begin
      w_fifo_word[EntValid]         = 1'b1;
      w_fifo_word[EntEof]           = w_head[EntryW-1];
      w_fifo_word[EntLevel]         = w_head[EntryW-2];
      w_fifo_word[EntDurLsb +: 16]  = 16'(w_head[DUR_W-1:0]);
    end
  end

  always_comb begin
    data_out = 32'd0;
    case (address)
      AddrCtrl:   data_out = r_ctrl;
      AddrStatus: data_out = w_status;
      AddrFifo:   data_out = w_fifo_word;
      default:    data_out = 32'd0;
    endcase
  end

  assign data_ready     = 1'b1;
  assign user_interrupt = (r_overflow & r_irq_en[0]) | (r_frame_done & r_irq_en[1]);

endmodule

// File: tb/tb_pulse_receiver_capture.sv
// tb_pulse_receiver_capture
// Directed bench for pulse_receiver_capture: duration capture, glitch filter,
// prescale/timeout with interrupt, full/overflow with same-cycle push+pop,
// empty and held reads, asynchronous reset mid-frame.
module tb_pulse_receiver_capture;

  logic        clk;
  logic        rst;
  logic [7:0]  ui_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_chk;
  int n_err;

  pulse_receiver_capture #(
    .FIFO_DEPTH (8),
    .DUR_W      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ui_in          (ui_in),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b10;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic peek(input logic [5:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = data_out;
  endtask

  // One-cycle FIFO read followed by an idle cycle so the next read is a new access.
  task automatic rd_fifo(output logic [31:0] v);
    address     = 6'h08;
    data_read_n = 2'b10;
    #1;
    v = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
    @(negedge clk);
  endtask

  logic [31:0] v;

  initial begin
    n_chk        = 0;
    n_err        = 0;
    rst          = 1'b1;
    ui_in        = 8'h00;
    address      = 6'h00;
    data_in      = 32'd0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;

    // Reset state
    peek(6'h04, v); chk("rst_status", v, 32'h0000_0001);
    peek(6'h08, v); chk("rst_fifo", v, 32'h0);
    peek(6'h00, v); chk("rst_ctrl", v, 32'h0);
    chk("rst_irq", {31'd0, user_interrupt}, 32'h0);
    chk("data_ready", {31'd0, data_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Duration capture: high 100, low 50, high 30
    wr(6'h00, 32'h0000_0001);
    ui_in[0] = 1'b1; repeat (100) @(negedge clk);
    ui_in[0] = 1'b0; repeat (50)  @(negedge clk);
    ui_in[0] = 1'b1; repeat (30)  @(negedge clk);
    peek(6'h04, v); chk("cap_status", v, 32'h0000_0020);
    rd_fifo(v); chk("cap_e0", v, 32'h8001_0063);
    rd_fifo(v); chk("cap_e1", v, 32'h8000_0031);
    rd_fifo(v); chk("cap_empty_rd", v, 32'h0);
    wr(6'h00, 32'h0);
    ui_in[0] = 1'b0; repeat (10) @(negedge clk);

    // Glitch filter, filt=3: 3-cycle glitch ignored, 5-cycle low captured
    wr(6'h00, 32'h0000_3001);
    ui_in[0] = 1'b1; repeat (100) @(negedge clk);
    ui_in[0] = 1'b0; repeat (3)   @(negedge clk);
    ui_in[0] = 1'b1; repeat (100) @(negedge clk);
    ui_in[0] = 1'b0; repeat (5)   @(negedge clk);
    ui_in[0] = 1'b1; repeat (60)  @(negedge clk);
    peek(6'h04, v); chk("filt_status", v, 32'h0000_0020);
    rd_fifo(v); chk("filt_high", v, 32'h8001_00CA);
    rd_fifo(v); chk("filt_low", v, 32'h8000_0004);
    wr(6'h00, 32'h0);
    ui_in[0] = 1'b0; repeat (10) @(negedge clk);

    // Prescale 16 and timeout 10 ticks
    wr(6'h00, 32'h000A_0401);
    ui_in[0] = 1'b1; repeat (64)  @(negedge clk);
    ui_in[0] = 1'b0; repeat (200) @(negedge clk);
    peek(6'h04, v); chk("to_status", v, 32'h0000_0028);
    chk("to_irq_masked", {31'd0, user_interrupt}, 32'h0);
    wr(6'h04, 32'h0000_0200);
    peek(6'h04, v); chk("to_status_ie", v, 32'h0000_0228);
    chk("to_irq_on", {31'd0, user_interrupt}, 32'h1);
    wr(6'h04, 32'h0000_0208);
    peek(6'h04, v); chk("to_status_clr", v, 32'h0000_0220);
    chk("to_irq_off", {31'd0, user_interrupt}, 32'h0);
    rd_fifo(v); chk("to_e0", v, 32'h8001_0003);
    rd_fifo(v); chk("to_eof", v, 32'h8002_000A);
    peek(6'h04, v); chk("to_status_end", v, 32'h0000_0201);
    wr(6'h04, 32'h0);
    wr(6'h00, 32'h0);
    repeat (5) @(negedge clk);

    // Full and overflow: 10 pushes with durations 9..18
    wr(6'h00, 32'h0000_0001);
    ui_in[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      repeat (9 + k) @(negedge clk);
      ui_in[0] = ~ui_in[0];
    end
    repeat (6) @(negedge clk);
    peek(6'h04, v); chk("ovf_status", v, 32'h0000_0086);
    chk("ovf_irq_masked", {31'd0, user_interrupt}, 32'h0);
    wr(6'h04, 32'h0000_0100);
    peek(6'h04, v); chk("ovf_status_ie", v, 32'h0000_0186);
    chk("ovf_irq_on", {31'd0, user_interrupt}, 32'h1);
    wr(6'h04, 32'h0000_0004);
    peek(6'h04, v); chk("ovf_status_clr", v, 32'h0000_0082);
    chk("ovf_irq_off", {31'd0, user_interrupt}, 32'h0);
    // Edge pushes 4 cycles after the pin change; align the pop with it.
    ui_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    rd_fifo(v); chk("pp_head", v, 32'h8001_0009);
    repeat (4) @(negedge clk);
    peek(6'h04, v); chk("pp_status", v, 32'h0000_0082);
    for (int k = 2; k <= 8; k++) begin
      rd_fifo(v);
      chk($sformatf("pp_e%0d", k), v, 32'h8000_0000 | (32'(k % 2) << 16) | 32'(8 + k));
    end
    rd_fifo(v); chk("pp_new", v & 32'hFFFF_0000, 32'h8001_0000);
    peek(6'h04, v); chk("pp_drained", v, 32'h0000_0001);
    wr(6'h00, 32'h0);
    repeat (5) @(negedge clk);

    // Held read: 3-cycle strobe pops exactly one of two entries
    wr(6'h00, 32'h0000_0001);
    ui_in[0] = 1'b1; repeat (20) @(negedge clk);
    ui_in[0] = 1'b0; repeat (30) @(negedge clk);
    ui_in[0] = 1'b1; repeat (5)  @(negedge clk);
    peek(6'h04, v); chk("hold_status", v, 32'h0000_0020);
    address     = 6'h08;
    data_read_n = 2'b10;
    #1;
    chk("hold_data", data_out, 32'h8001_0013);
    repeat (3) @(negedge clk);
    data_read_n = 2'b11;
    @(negedge clk);
    peek(6'h04, v); chk("hold_status_after", v, 32'h0000_0010);
    rd_fifo(v); chk("hold_e1", v, 32'h8000_001D);
    rd_fifo(v); chk("hold_empty_rd", v, 32'h0);
    peek(6'h04, v); chk("hold_empty_status", v, 32'h0000_0001);

    // Reset in MEASURE with 4 entries queued
    for (int i = 0; i < 4; i++) begin
      ui_in[0] = ~ui_in[0];
      repeat (10) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    peek(6'h04, v); chk("pre_rst_status", v, 32'h0000_0040);
    rst      = 1'b1;
    ui_in[0] = 1'b0;
    peek(6'h04, v); chk("arst_status", v, 32'h0000_0001);
    peek(6'h08, v); chk("arst_fifo", v, 32'h0);
    chk("arst_irq", {31'd0, user_interrupt}, 32'h0);
    peek(6'h00, v); chk("arst_ctrl", v, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr(6'h00, 32'h0000_0001);
    repeat (5) @(negedge clk);
    ui_in[0] = 1'b1; repeat (40) @(negedge clk);
    ui_in[0] = 1'b0; repeat (25) @(negedge clk);
    ui_in[0] = 1'b1; repeat (5)  @(negedge clk);
    peek(6'h04, v); chk("resume_status", v, 32'h0000_0020);
    rd_fifo(v); chk("resume_e0", v, 32'h8001_0027);
    rd_fifo(v); chk("resume_e1", v, 32'h8000_0018);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pulse_receiver_capture.md
# pulse_receiver_capture

Measures the level durations of a pulse train on one selectable `ui_in` pin and queues them for software as (level, duration) entries. It sits directly downstream of the pulse transmitter's output, either looped back or received from an external IR/one-wire line. It is a TinyQV user peripheral: captured entries are read out through the standard peripheral register port, and an interrupt signals frame end or overflow.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: number of capture entries; power of 2, at least 2.
- `DUR_W`, 16: width of the duration field and the tick counter.

Ports:
- `clk`  in  1  peripheral clock (64 MHz nominal).
- `rst`  in  1  reset; asynchronous, active-high. All state clears immediately.
- `ui_in`  in  8  input PMOD; the captured pin is selected by `CTRL.pin`.
- `address`  in  6  register offset.
- `data_in`  in  32  write data.
- `data_write_n`  in  2  11 = none, 00 = 8-bit, 01 = 16-bit, 10 = 32-bit.
- `data_read_n`  in  2  same encoding as `data_write_n`, for reads.
- `data_out`  out  32  read data, selected by `address`; 0 after reset.
- `data_ready`  out  1  tied to 1.
- `user_interrupt`  out  1  equals `|(STATUS[3:2] & STATUS[9:8])`; 0 after reset.

## Operation
Register map (32-bit writes only; other write sizes are ignored):
- 0x00 CTRL, reset 0:
  - [0] `en`
  - [1] `invert`
  - [4:2] `pin`
  - [11:8] `presc` (tick every 2^presc cycles)
  - [15:12] `filt`
  - [31:16] `timeout` in ticks; 0 disables the timeout.
- 0x04 STATUS:
  - [0] empty, [1] full (read-only).
  - [2] overflow, [3] frame_done: sticky; writing 1 clears the bit.
  - [7:4] occupancy, saturating at 15.
  - [9:8] interrupt enables for overflow and frame_done (read/write).
- 0x08 FIFO: a read returns the head entry and pops it:
  - [31] valid
  - [17] eof
  - [16] level
  - [15:0] duration

Input conditioning:
- 2-flop synchroniser, then `invert`, then a glitch filter.
- The filtered level `lvl` flips only after the synchronised input has differed from `lvl` for `filt`+1 consecutive cycles. Any agreement resets the filter count.

Tick generation and measurement:
- A prescale counter runs only while `en`=1. It produces a 1-cycle tick when it reaches 2^presc−1, then wraps to 0.
- The duration counter increments on each tick and saturates at 2^DUR_W−1; it never wraps.

Capture FSM:
- IDLE, on entry: duration counter and prescaler cleared.
  - A `lvl` edge → MEASURE.
- MEASURE:
  - On a `lvl` edge: push {eof=0, level=old `lvl`, duration}; clear the duration counter and prescaler in the same cycle.
  - When `timeout`≠0 and duration == `timeout`: push {eof=1, level=`lvl`, duration}, set frame_done → IDLE.
- `en`=0 in any state → IDLE. The FIFO contents are kept.

Boundary conditions:
- Push while full: the entry is dropped and overflow is set, except when a pop happens in the same cycle, in which case the push is accepted.
- FIFO read while empty: returns 0 (valid=0) and does not pop.
- A pop happens once per read access, on the first cycle where `data_read_n`≠11 with `address`=0x08. A read held over several cycles pops once.
- Duration saturated and `timeout` > saturation value: no eof is generated; the next edge pushes 0xFFFF.
- Set and clear in the same cycle: a status event wins over a software clear of the same bit.

## Timing
Latency through the input path:
- Pin change → `lvl` change: 2 + `filt` + 1 cycles.
- `lvl` edge → entry visible in FIFO/STATUS: 1 cycle.

Duration semantics:
- The duration is the number of ticks between consecutive `lvl` edges.
- A level held for N cycles with presc=0 reads N−1±0 (counter cleared on the edge cycle). A bench must compare against N−1.

Register port:
- Reads are combinational from current state; `data_ready` is always 1.
- The pop takes effect on the clock edge that ends the first read cycle.
- Register writes take effect on the next clock edge.
- Reset mid-frame: the FSM returns to IDLE, the FIFO is empty, and all registers and `user_interrupt` are 0 immediately (asynchronous).

## Structure
Shared package `pulse_receiver_pkg` holds:
- register offsets (0x00/0x04/0x08);
- CTRL/STATUS bit positions;
- entry field positions;
- FSM state encoding {IDLE, MEASURE}.

The FIFO is a separate sub-module, `pulse_receiver_fifo`: synchronous, single clock, with push/pop/full/empty/count and a same-cycle push+pop rule. Synchroniser, filter, prescaler, FSM and register decode stay in the top level.

## Test plan
- Duration capture: presc=0, filt=0, timeout=0; pin0 driven high 100 cycles, low 50, high 30 → entries {level1, 99} and {level0, 49}; valid=1, eof=0.
- Glitch filter: filt=3; 3-cycle low glitch inside a 200-cycle high → no entry. A 5-cycle low → the low pulse is captured.
- Prescale and timeout: presc=4, timeout=10; high for 64 cycles then left low → {level1, 3}, then {eof=1, level0, 10}; frame_done set; `user_interrupt` rises only when enable bit 9 = 1; writing 1 to bit 3 clears it.
- Full and overflow: 10 edges with no reads (FIFO_DEPTH=8) → full=1, occupancy=8, overflow=1, the oldest 8 entries are preserved. Then a push and a pop in the same cycle → no additional overflow.
- Empty and held reads: FIFO read when empty returns 0; a 3-cycle read strobe with 2 entries pops exactly one entry.
- Reset: assert `rst` in MEASURE with 4 entries queued → empty=1, `data_out`=0, `user_interrupt`=0 with no clock edge; after release, capture resumes from IDLE.
